vga_timing_gen: RTL and testbench

Generates raster timing for the framebuffer display path: active-low Hsync/Vsync, DE and pixel coordinates at pixel rate.
Sits directly upstream of the BRAM address controller, which takes its Hsync and Vsync outputs.
Also feeds the RGB output stage with DE and coordinates.
Run/stop control with frame-aligned shutdown, so downstream address counters never see a truncated frame.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 20 ++
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the run/stop state encoding for the
// VGA timing generator.
package vga_timing_pkg;
  localparam int P_H_ACTIVE = 640;
  localparam int P_H_FP     = 16;
  localparam int P_H_SYNC   = 96;
  localparam int P_H_BP     = 48;
  localparam int P_V_ACTIVE = 480;
  localparam int P_V_FP     = 10;
  localparam int P_V_SYNC   = 2;
  localparam int P_V_BP     = 33;
  localparam int P_CW       = 12;

  localparam int P_H_TOTAL  = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int P_V_TOTAL  = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
  localparam int P_HS_START = P_H_ACTIVE + P_H_FP;
  localparam int P_HS_END   = P_HS_START + P_H_SYNC;
  localparam int P_VS_START = P_V_ACTIVE + P_V_FP;
  localparam int P_VS_END   = P_VS_START + P_V_SYNC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts on inc, wraps to 0 after TERM, flags the terminal value.
module vga_axis_counter #(
  parameter int            CW   = 12,
  parameter logic [CW-1:0] TERM = '0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap
);
  assign wrap = (cnt == TERM);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: run/stop FSM with frame-aligned drain, registered
// sync/DE/coordinate outputs decoded from the pre-increment counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = P_H_ACTIVE,
  parameter int H_FP     = P_H_FP,
  parameter int H_SYNC   = P_H_SYNC,
  parameter int H_BP     = P_H_BP,
  parameter int V_ACTIVE = P_V_ACTIVE,
  parameter int V_FP     = P_V_FP,
  parameter int V_SYNC   = P_V_SYNC,
  parameter int V_BP     = P_V_BP,
  parameter int CW       = P_CW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CE,
  input  logic          EN,
  output logic          Hsync,
  output logic          Vsync,
  output logic          DE,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_LO  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_HI  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_LO  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_HI  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  state_t        state;
  logic [CW-1:0] h, v;
  logic          h_wrap, v_wrap;
  logic          scan, run_tick, idle_tick;

  // The IDLE->RUN edge already scans position 0,0, so a start costs no tick.
  assign scan      = (state != IDLE) || EN;
  assign run_tick  = CE && scan;
  assign idle_tick = CE && !scan;

  vga_axis_counter #(.CW(CW), .TERM(H_LAST)) u_hcnt (
    .CLK(CLK), .RESET(RESET), .clr(idle_tick), .inc(run_tick),
    .cnt(h), .wrap(h_wrap)
  );

  vga_axis_counter #(.CW(CW), .TERM(V_LAST)) u_vcnt (
    .CLK(CLK), .RESET(RESET), .clr(idle_tick), .inc(run_tick && h_wrap),
    .cnt(v), .wrap(v_wrap)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      Hsync       <= 1'b1;
      Vsync       <= 1'b1;
      DE          <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (CE) begin
      if (scan) begin
        Hsync       <= !((h >= HS_LO) && (h < HS_HI));
        Vsync       <= !((v >= VS_LO) && (v < VS_HI));
        DE          <= (h < H_ACT) && (v < V_ACT);
        hpos        <= h;
        vpos        <= v;
        line_start  <= (h == '0);
        frame_start <= (h == '0) && (v == '0);
        busy        <= 1'b1;
      end else begin
        Hsync       <= 1'b1;
        Vsync       <= 1'b1;
        DE          <= 1'b0;
        hpos        <= '0;
        vpos        <= '0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
        busy        <= 1'b0;
      end

      // A re-request on the final drain tick wins, so frames run back to back.
      case (state)
        IDLE:    if (EN) state <= RUN;
        RUN:     if (!EN) state <= DRAIN;
        DRAIN:   if (EN) state <= RUN;
                 else if (h_wrap && v_wrap) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a small-raster instance checked tick by tick against a
// reference model, plus a default-parameter instance for 640x480 line timing.
module tb_vga_timing_gen;
  logic        CLK = 1'b0;
  logic        RESET, CE, EN, CE2, EN2;
  logic        Hsync, Vsync, DE, line_start, frame_start, busy;
  logic [11:0] hpos, vpos;
  logic        Hsync2, Vsync2, DE2, line_start2, frame_start2, busy2;
  logic [11:0] hpos2, vpos2;

  typedef logic [29:0] vec_t;
  vec_t sb[$];
  vec_t last_exp, got, exp_v;
  int   mst;
  logic [11:0] mh, mv;
  int   passed = 0, total = 0;

  always #5 CLK = ~CLK;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(12)
  ) u_dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .EN(EN),
    .Hsync(Hsync), .Vsync(Vsync), .DE(DE), .hpos(hpos), .vpos(vpos),
    .line_start(line_start), .frame_start(frame_start), .busy(busy)
  );

  vga_timing_gen u_big (
    .CLK(CLK), .RESET(RESET), .CE(CE2), .EN(EN2),
    .Hsync(Hsync2), .Vsync(Vsync2), .DE(DE2), .hpos(hpos2), .vpos(vpos2),
    .line_start(line_start2), .frame_start(frame_start2), .busy(busy2)
  );

  function automatic vec_t idle_vec();
    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
  endfunction

  function automatic vec_t dut_vec();
    return {Hsync, Vsync, DE, busy, line_start, frame_start, hpos, vpos};
  endfunction

  task automatic model_reset();
    mst = 0; mh = '0; mv = '0; last_exp = idle_vec(); sb.delete();
  endtask

  // Drive one CLK cycle on the small instance and queue what it must show after it.
  task automatic step(input logic en, input logic ce);
    vec_t e;
    EN = en; CE = ce;
    if (ce) begin
      if (mst == 0 && !en) e = idle_vec();
      else begin
        e = {!(mh >= 12'd5 && mh < 12'd7), !(mv == 12'd4), (mh < 12'd4 && mv < 12'd3),
             1'b1, (mh == 12'd0), (mh == 12'd0 && mv == 12'd0), mh, mv};
        if (mst == 0) mst = 1;
        else if (mst == 1 && !en) mst = 2;
        else if (mst == 2) begin
          if (en) mst = 1;
          else if (mh == 12'd7 && mv == 12'd5) mst = 0;
        end
        if (mh == 12'd7) begin
          mh = '0;
          mv = (mv == 12'd5) ? 12'd0 : mv + 12'd1;
        end else mh = mh + 12'd1;
      end
      last_exp = e;
    end else e = last_exp;
    sb.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; CE = 1'b0; EN = 1'b0; CE2 = 1'b0; EN2 = 1'b0;
    model_reset();
    #1;
    got = dut_vec(); total++;
    if (got !== idle_vec()) $display("FAIL reset_state got=%h exp=%h", got, idle_vec());
    else passed++;
    #20;
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;
    got = dut_vec(); total++;
    if (got !== idle_vec()) $display("FAIL reset_hold got=%h exp=%h", got, idle_vec());
    else passed++;
  endtask

  task automatic test_first_tick();
    step(1'b1, 1'b1);
    got = dut_vec(); exp_v = sb.pop_front(); total++;
    if (got !== exp_v) $display("FAIL first_tick_sb got=%h exp=%h", got, exp_v); else passed++;
    total++;
    if ({DE, frame_start, line_start, Hsync, Vsync, hpos, vpos} !== {5'b11111, 24'd0})
      $display("FAIL first_tick got=%b%b%b%b%b h=%0d v=%0d exp=11111 h=0 v=0",
               DE, frame_start, line_start, Hsync, Vsync, hpos, vpos);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1);
      got = dut_vec(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) $display("FAIL first_line_sb i=%0d got=%h exp=%h", i, got, exp_v);
      else passed++;
    end
    total++;
    if (DE !== 1'b0 || hpos !== 12'd4) $display("FAIL de_off_h4 got DE=%b h=%0d exp DE=0 h=4", DE, hpos);
    else passed++;
  endtask

  task automatic test_frame();
    int fs[$];
    int de_cnt = 0, hs_cnt = 0, hs_bad = 0, vs_cnt = 0, vs_bad = 0;
    for (int i = 0; i < 120; i++) begin
      step(1'b1, 1'b1);
      got = dut_vec(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) $display("FAIL frame_sb i=%0d got=%h exp=%h", i, got, exp_v); else passed++;
      if (frame_start) fs.push_back(i);
      if (fs.size() > 0 && i < fs[0] + 48) begin
        if (DE) de_cnt++;
        if (!Hsync) begin hs_cnt++; if (hpos != 12'd5 && hpos != 12'd6) hs_bad++; end
        if (!Vsync) begin vs_cnt++; if (vpos != 12'd4) vs_bad++; end
      end
    end
    total++;
    if (fs.size() < 2 || fs[1] - fs[0] != 48)
      $display("FAIL frame_period got=%0d exp=48", (fs.size() < 2) ? -1 : fs[1] - fs[0]);
    else passed++;
    total++;
    if (de_cnt != 12) $display("FAIL de_count got=%0d exp=12", de_cnt); else passed++;
    total++;
    if (hs_cnt != 12 || hs_bad != 0) $display("FAIL hsync_win got=%0d bad=%0d exp=12 bad=0", hs_cnt, hs_bad);
    else passed++;
    total++;
    if (vs_cnt != 8 || vs_bad != 0) $display("FAIL vsync_win got=%0d bad=%0d exp=8 bad=0", vs_cnt, vs_bad);
    else passed++;
  endtask

  task automatic test_drain();
    logic [11:0] lh = '0, lv = '0;
    int n = 0;
    while (!(hpos == 12'd1 && vpos == 12'd1) && n < 60) begin
      step(1'b1, 1'b1); n++;
      got = dut_vec(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) $display("FAIL pre_drain_sb got=%h exp=%h", got, exp_v); else passed++;
    end
    n = 0;
    do begin
      if (busy) begin lh = hpos; lv = vpos; end
      step(1'b0, 1'b1); n++;
      got = dut_vec(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) $display("FAIL drain_sb got=%h exp=%h", got, exp_v); else passed++;
    end while (busy && n < 80);
    total++;
    if (busy !== 1'b0 || lh !== 12'd7 || lv !== 12'd5)
      $display("FAIL drain_end got busy=%b last=%0d,%0d exp busy=0 last=7,5", busy, lh, lv);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      got = dut_vec(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) $display("FAIL idle_sb got=%h exp=%h", got, exp_v); else passed++;
    end
    total++;
    if (hpos !== 12'd0 || vpos !== 12'd0 || busy !== 1'b0)
      $display("FAIL idle_hold got h=%0d v=%0d busy=%b exp 0 0 0", hpos, vpos, busy);
    else passed++;
  endtask

  task automatic test_reenter();
    int cont_bad = 0, fs_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(!(i >= 20 && i < 26), 1'b1);
      got = dut_vec(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) $display("FAIL reenter_sb i=%0d got=%h exp=%h", i, got, exp_v); else passed++;
      if (hpos !== 12'(i % 8) || vpos !== 12'((i / 8) % 6) || busy !== 1'b1) cont_bad++;
      if (frame_start !== (i % 48 == 0)) fs_bad++;
    end
    total++;
    if (cont_bad != 0) $display("FAIL reenter_continuity got=%0d exp=0", cont_bad); else passed++;
    total++;
    if (fs_bad != 0) $display("FAIL reenter_frame_start got=%0d exp=0", fs_bad); else passed++;
  endtask

  task automatic test_ce_gating();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 1) step(1'($urandom), 1'b0);
      else step(1'b1, 1'b1);
      got = dut_vec(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) $display("FAIL ce_gate_sb i=%0d got=%h exp=%h", i, got, exp_v); else passed++;
    end
  endtask

  task automatic test_default();
    int k = 0, ls0 = -1, ls1 = -1, hs_first = -1, hs_cnt = 0;
    logic [11:0] v800 = '0;
    logic de639 = 1'b0, de640 = 1'b1, first_ok = 1'b0;
    CE = 1'b0;
    for (int c = 0; c < 3400; c++) begin
      CE2 = (c % 2 == 0); EN2 = 1'b1;
      @(posedge CLK); #1;
      if (c % 2 == 0) begin
        if (k == 0) first_ok = frame_start2 && line_start2 && DE2 && Hsync2 && Vsync2 && hpos2 == 12'd0;
        if (line_start2 && vpos2 == 12'd0 && ls0 < 0) ls0 = c;
        if (line_start2 && vpos2 == 12'd1 && ls1 < 0) ls1 = c;
        if (!Hsync2 && vpos2 == 12'd0) begin if (hs_first < 0) hs_first = int'(hpos2); hs_cnt++; end
        if (k == 639) de639 = DE2;
        if (k == 640) de640 = DE2;
        if (k == 800) v800 = vpos2;
        k++;
      end
    end
    CE2 = 1'b0; EN2 = 1'b0;
    total++;
    if (!first_ok) $display("FAIL big_first_tick got=0 exp=1"); else passed++;
    total++;
    if (ls1 - ls0 != 1600) $display("FAIL big_line_period got=%0d exp=1600", ls1 - ls0); else passed++;
    total++;
    if (hs_first != 656 || hs_cnt != 96) $display("FAIL big_hsync got start=%0d len=%0d exp 656 96", hs_first, hs_cnt);
    else passed++;
    total++;
    if (de639 !== 1'b1 || de640 !== 1'b0) $display("FAIL big_de_edge got=%b%b exp=10", de639, de640); else passed++;
    total++;
    if (v800 !== 12'd1) $display("FAIL big_vpos_step got=%0d exp=1", v800); else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(hpos == 12'd3 && vpos == 12'd2 && busy) && n < 60) begin
      step(1'b1, 1'b1); n++;
      got = dut_vec(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) $display("FAIL pre_reset_sb got=%h exp=%h", got, exp_v); else passed++;
    end
    #3 RESET = 1'b1;
    #1;
    got = dut_vec(); total++;
    if (got !== idle_vec()) $display("FAIL async_reset got=%h exp=%h", got, idle_vec()); else passed++;
    @(negedge CLK); CE = 1'b0; EN = 1'b1; RESET = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    step(1'b1, 1'b1);
    got = dut_vec(); exp_v = sb.pop_front(); total++;
    if (got !== exp_v) $display("FAIL restart_sb got=%h exp=%h", got, exp_v); else passed++;
    total++;
    if (frame_start !== 1'b1 || hpos !== 12'd0 || vpos !== 12'd0)
      $display("FAIL restart got fs=%b h=%0d v=%0d exp fs=1 h=0 v=0", frame_start, hpos, vpos);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_frame();
    test_drain();
    test_reenter();
    test_ce_gating();
    test_default();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
